// File: rtl/fifo_blk_reader.sv
// Read-side consumer of the 66b async block FIFO: credit-based read issue, skid store, header check.
// Optional IDLE_FILL_EN: emit idle control blocks while the store is empty.
module fifo_blk_reader #(
  parameter int unsigned DATA_WIDTH    = 66,
  parameter int unsigned RD_LATENCY    = 1,
  parameter int unsigned BUF_DEPTH     = 4,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst,
  output logic                         fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]        fifo_rd_data,
  input  logic                         fifo_rd_empty,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_hdr_err,
  output logic                         out_idle,
  output logic [$clog2(BUF_DEPTH):0]   buf_level,
  output logic [ERR_CNT_WIDTH-1:0]     err_cnt
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CR_W  = LVL_W + 1;

  logic [RD_LATENCY-1:0]    r_vld;
  logic [DATA_WIDTH-1:0]    r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [LVL_W-1:0]         r_level;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  logic [CR_W-1:0]          w_inflight;
  logic [CR_W-1:0]          w_credit;
  logic                     w_store_vld;
  logic                     w_pop;
  logic                     w_push;
  logic [DATA_WIDTH-1:0]    w_head;
  logic [1:0]               w_hdr;
  logic                     w_head_err;

  // Reads already issued but not yet returned by the FIFO
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      w_inflight = w_inflight + CR_W'(r_vld[i]);
    end
  end

  assign w_store_vld = (r_level != '0);
  assign w_pop       = w_store_vld && out_ready;
  assign w_push      = r_vld[RD_LATENCY-1];
  assign w_credit    = CR_W'(r_level) + w_inflight;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_hdr       = w_head[DATA_WIDTH-1 -: 2];
  assign w_head_err  = (w_hdr == 2'b00) || (w_hdr == 2'b11);

  // A slot freed by this cycle's pop may be re-issued immediately
  assign fifo_rd_en = !fifo_rd_empty && !rd_rst &&
                      ((w_credit - CR_W'(w_pop)) < CR_W'(BUF_DEPTH));

`ifdef IDLE_FILL_EN
  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {2'b10, (DATA_WIDTH-2)'(8'h1E)};
  logic w_fill;

  assign w_fill    = !w_store_vld && out_ready && !rd_rst;
  assign out_valid = w_store_vld || w_fill;
  assign out_idle  = w_fill;
  assign out_data  = w_store_vld ? w_head : (w_fill ? IDLE_WORD : '0);
`else
  assign out_valid = w_store_vld;
  assign out_idle  = 1'b0;
  assign out_data  = w_store_vld ? w_head : '0;
`endif

  assign out_hdr_err = w_store_vld && w_head_err;
  assign buf_level   = r_level;
  assign err_cnt     = r_err_cnt;

  // Control state: latency tracker, pointers, level, error counter
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_vld     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_err_cnt <= '0;
    end else begin
      r_vld[0] <= fifo_rd_en;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        r_vld[i] <= r_vld[i-1];
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: ;
      endcase
      if (w_pop && w_head_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
      end
    end
  end

  // Storage array, no reset needed: contents are only visible when level is nonzero
  always_ff @(posedge rd_clk) begin
    if (w_push && !rd_rst) r_mem[r_wr_ptr] <= fifo_rd_data;
  end

endmodule

// File: tb/tb_fifo_blk_reader.sv
// Testbench for fifo_blk_reader: FIFO model with 1-cycle read latency, vector tables and directed sequences.
module tb_fifo_blk_reader;

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        fifo_rd_en;
  logic [65:0] fifo_rd_data;
  logic        fifo_rd_empty;
  logic        out_valid;
  logic        out_ready;
  logic [65:0] out_data;
  logic        out_hdr_err;
  logic        out_idle;
  logic [2:0]  buf_level;
  logic [15:0] err_cnt;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  fifo_blk_reader #(
    .DATA_WIDTH(66), .RD_LATENCY(1), .BUF_DEPTH(4), .ERR_CNT_WIDTH(16)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_hdr_err(out_hdr_err), .out_idle(out_idle),
    .buf_level(buf_level), .err_cnt(err_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model, standard mode, one cycle read latency
  logic [65:0] src_mem [0:63];
  int unsigned src_wr = 0;
  int unsigned src_rd = 0;
  bit          src_inf = 1'b0;

  always_comb fifo_rd_empty = src_inf ? 1'b0 : (src_wr == src_rd);

  initial fifo_rd_data = '0;
  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      if (src_inf) fifo_rd_data <= {2'b11, 64'(src_rd)};
      else         fifo_rd_data <= src_mem[src_rd[5:0]];
      src_rd <= src_rd + 1;
    end
  end

  // Scoreboard of accepted real words
  logic [65:0] acc_q[$];
  int unsigned n_bad = 0;
  always @(posedge rd_clk) begin
    if (!rd_rst && out_valid && out_ready && !out_idle) begin
      acc_q.push_back(out_data);
      if (out_data[65:64] == 2'b00 || out_data[65:64] == 2'b11) n_bad <= n_bad + 1;
    end
  end

  typedef struct {
    bit          rdy;
    bit          en;
    bit          vld;
    int unsigned pay;
    int unsigned lvl;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [1:0] hdr, input int unsigned pay);
    src_mem[src_wr[5:0]] = {hdr, 64'(pay)};
    src_wr = src_wr + 1;
  endtask

  // Leaves rd_rst high at a falling edge; caller preloads and releases
  task automatic do_reset();
    rd_rst    = 1'b1;
    out_ready = 1'b0;
    src_inf   = 1'b0;
    repeat (3) @(negedge rd_clk);
    src_wr = src_rd;
  endtask

  task automatic run_vec(input int unsigned idx);
    out_ready = vt[idx].rdy;
    #1;
    chk($sformatf("v%0d_rd_en", idx), 66'(fifo_rd_en), 66'(vt[idx].en));
    chk($sformatf("v%0d_valid", idx), 66'(out_valid),  66'(vt[idx].vld));
    chk($sformatf("v%0d_level", idx), 66'(buf_level),  66'(vt[idx].lvl));
    if (vt[idx].vld) chk($sformatf("v%0d_data", idx), out_data, {2'b01, 64'(vt[idx].pay)});
    @(negedge rd_clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned base;
    int unsigned bad_base;
    int unsigned nv;
    bit          hit;

    // Streaming with ready high: issue every cycle, data two cycles behind
    vt[0] = '{1, 1, 0, 0, 0};
    vt[1] = '{1, 1, 0, 0, 0};
    for (int k = 2; k < 8; k++) vt[k] = '{1, 1, 1, k - 2, 1};
    vt[8]  = '{1, 0, 1, 6, 1};
    vt[9]  = '{1, 0, 1, 7, 1};
    vt[10] = '{1, 0, 0, 0, 0};
    // Back-pressure: exactly four reads issued, head word held
    vt[11] = '{0, 1, 0, 0, 0};
    vt[12] = '{0, 1, 0, 0, 0};
    vt[13] = '{0, 1, 1, 0, 1};
    vt[14] = '{0, 1, 1, 0, 2};
    vt[15] = '{0, 0, 1, 0, 3};
    vt[16] = '{0, 0, 1, 0, 4};
    vt[17] = '{0, 0, 1, 0, 4};

    rd_rst = 1'b1;
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) push_word(2'b01, i);
    #1;
    chk("rst_rd_en", 66'(fifo_rd_en), 66'(0));
    chk("rst_valid", 66'(out_valid), 66'(0));
    chk("rst_data",  out_data, 66'(0));
    chk("rst_level", 66'(buf_level), 66'(0));
    chk("rst_err",   66'(err_cnt), 66'(0));
    chk("rst_idle",  66'(out_idle), 66'(0));
    rd_rst = 1'b0;
    for (int i = 0; i < 11; i++) run_vec(i);
    chk("t1_err_cnt", 66'(err_cnt), 66'(0));

    do_reset();
    for (int i = 0; i < 10; i++) push_word(2'b01, i);
    rd_rst = 1'b0;
    for (int i = 11; i < 18; i++) run_vec(i);
    base = acc_q.size();
    out_ready = 1'b1;
    for (int c = 0; c < 40 && acc_q.size() < base + 10; c++) @(negedge rd_clk);
    repeat (3) @(negedge rd_clk);
    chk("t2_count", 66'(acc_q.size() - base), 66'(10));
    for (int i = 0; i < 10 && base + i < acc_q.size(); i++)
      chk($sformatf("t2_word%0d", i), acc_q[base + i], {2'b01, 64'(i)});

    // Header error flag on one word, counter of accepted errors
    do_reset();
    push_word(2'b01, 0);
    push_word(2'b11, 1);
    push_word(2'b10, 2);
    push_word(2'b01, 3);
    rd_rst = 1'b0;
    bad_base = n_bad;
    out_ready = 1'b1;
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (out_valid) begin
        nv++;
        chk($sformatf("t3_hdr_err_c%0d", c), 66'(out_hdr_err), 66'(out_data[63:0] == 64'd1));
      end
      @(negedge rd_clk);
    end
    chk("t3_valid_words", 66'(nv), 66'(4));
    chk("t3_err_cnt", 66'(err_cnt), 66'(1));

    // Saturation: stream bad headers continuously
    src_inf = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 70000 && (n_bad - bad_base) < 65540; c++) begin
      @(negedge rd_clk);
      #1;
      if (!hit && (n_bad - bad_base) == 65534) begin
        hit = 1'b1;
        chk("t3_err_cnt_fffe", 66'(err_cnt), 66'(16'hFFFE));
      end
    end
    chk("t3_sat_reached", 66'(hit && (n_bad - bad_base) >= 65540), 66'(1));
    chk("t3_err_cnt_sat", 66'(err_cnt), 66'(16'hFFFF));

    // Ready toggling: 20 words through the wrapping store
    do_reset();
    for (int i = 0; i < 20; i++) push_word(2'b01, 100 + i);
    rd_rst = 1'b0;
    base = acc_q.size();
    for (int c = 0; c < 200 && acc_q.size() < base + 20; c++) begin
      out_ready = (c % 2) == 0;
      @(negedge rd_clk);
    end
    out_ready = 1'b1;
    repeat (5) @(negedge rd_clk);
    chk("t4_count", 66'(acc_q.size() - base), 66'(20));
    for (int i = 0; i < 20 && base + i < acc_q.size(); i++)
      chk($sformatf("t4_word%0d", i), acc_q[base + i], {2'b01, 64'(100 + i)});

    // Reset one cycle after a read issue discards the returned word
    do_reset();
    rd_rst = 1'b0;
    @(negedge rd_clk);
    push_word(2'b11, 55);
    #1;
    chk("t5_rd_en", 66'(fifo_rd_en), 66'(1));
    @(negedge rd_clk);
    rd_rst = 1'b1;
    @(negedge rd_clk);
    #1;
    chk("t5_rd_en0", 66'(fifo_rd_en), 66'(0));
    chk("t5_valid0", 66'(out_valid), 66'(0));
    chk("t5_data0",  out_data, 66'(0));
    chk("t5_hdr0",   66'(out_hdr_err), 66'(0));
    chk("t5_idle0",  66'(out_idle), 66'(0));
    chk("t5_level0", 66'(buf_level), 66'(0));
    chk("t5_err0",   66'(err_cnt), 66'(0));
    rd_rst = 1'b0;
    repeat (2) @(negedge rd_clk);
    #1;
    chk("t5_level_after", 66'(buf_level), 66'(0));
    chk("t5_valid_after", 66'(out_valid), 66'(0));

    // Empty FIFO with ready high
    do_reset();
    rd_rst = 1'b0;
    out_ready = 1'b1;
    @(negedge rd_clk);
    for (int c = 0; c < 3; c++) begin
      #1;
`ifdef IDLE_FILL_EN
      chk($sformatf("t6_valid%0d", c), 66'(out_valid), 66'(1));
      chk($sformatf("t6_idle%0d", c),  66'(out_idle), 66'(1));
      chk($sformatf("t6_data%0d", c),  out_data, 66'h2_0000_0000_0000_001E);
`else
      chk($sformatf("t6_valid%0d", c), 66'(out_valid), 66'(0));
      chk($sformatf("t6_idle%0d", c),  66'(out_idle), 66'(0));
`endif
      chk($sformatf("t6_level%0d", c), 66'(buf_level), 66'(0));
      @(negedge rd_clk);
    end
    push_word(2'b01, 77);
    nv = 0;
    for (int c = 0; c < 10 && nv == 0; c++) begin
      @(negedge rd_clk);
      #1;
      if (out_valid && !out_idle) begin
        nv = 1;
        chk("t6_real_data", out_data, {2'b01, 64'd77});
      end
    end
    chk("t6_real_seen", 66'(nv), 66'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
